csr_axil_slave: RTL and testbench
=================================

# csr_axil_slave

AXI4-Lite responder that terminates the CPU control port of the accelerator and implements the CSR register file. It sits inside the top wrapper, directly behind the S_AXI_* pins. It holds the writable configuration registers that drive the operator engines, such as the softmax Head/Win/CH/address/stride fields. It also returns engine-supplied read-only status and performance counters, for example the DMA data performance counter at index 219.

## Interface
Parameters:
- CSR_REG_NUM, 256: total 32-bit registers.
- ADDR_W, log2(CSR_REG_NUM)+2: byte address width.
- RO_BASE, 192: indices ≥ RO_BASE are read-only and sourced from ro_regs; indices < RO_BASE are read/write.

Ports (clock and reset first):
- clk  in  1  the single clock.
- rst_n  in  1  reset; synchronous, active-low.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_AWADDR  in  ADDR_W  byte address; bits [1:0] ignored.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_ARADDR  in  ADDR_W  byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
- csr_regs  out  RO_BASE*32  flattened R/W registers; register i occupies [32i+:32].
- ro_regs  in  (CSR_REG_NUM-RO_BASE)*32  read-only values; index RO_BASE+j occupies [32j+:32].
- csr_wr_en  out  1  one-cycle pulse on each committed write to an R/W register.
- csr_wr_idx  out  log2(CSR_REG_NUM)  register index of that write.

## Operation
- **Write path.** AW and W are captured independently into one-deep holding registers.
  - AWREADY = !aw_held; WREADY = !w_held.
  - Commit occurs in the cycle both are held and BVALID=0. Address and data may arrive in either order, on any cycles.
  - Commit updates reg[idx] per WSTRB byte lanes; unstrobed bytes are unchanged.
  - Commit also pulses csr_wr_en with csr_wr_idx=idx, sets BVALID=1, and clears both holds.
  - Write to idx ≥ RO_BASE: register unchanged, no csr_wr_en, BVALID still returned with OKAY.
- **Read path.** ARREADY = !RVALID.
  - On AR handshake, RDATA is registered: reg[idx] if idx < RO_BASE, else ro_regs slot idx-RO_BASE.
  - RVALID is held until RREADY.
- **Simultaneous events.** A read handshake in the same cycle as a write commit to the same index returns the pre-write value.
- **Reset.** All registers = 0; BVALID, RVALID, csr_wr_en, aw_held, w_held = 0; RDATA = 0; csr_wr_idx = 0. Reset mid-transaction discards held AW/W and any pending B/R response.

## Timing
- Reset-asserted output values: AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=0, RRESP=0, csr_wr_en=0.
- AW and W handshaked in cycle 0 → in cycle 1: csr_regs updated, csr_wr_en=1, BVALID=1, AWREADY=WREADY=1. Write latency is 1 cycle after the later of the two handshakes.
- BVALID stays 1 while BREADY=0. A further AW/W pair may be captured meanwhile, but its commit waits until the cycle after the B handshake.
- AR handshake in cycle 0 → RVALID=1 and RDATA valid in cycle 1. With RREADY held 1, one read completes every 2 cycles.
- ro_regs are sampled in the AR handshake cycle; later changes do not alter a pending RDATA.

## Structure
- Shared package (csr_pkg): CSR_REG_NUM, RO_BASE, a typedef for register index width, and named localparams for register indices used by engines. One example is DMA_DAT_PERF_CNT = RO_BASE+27.
- One natural sub-module: csr_axil_wr_hold, the one-deep AW/W capture with ready generation, instantiated twice.

## Test plan
- Write 0xDEADBEEF to byte address 0x010 with AW and W in the same cycle → cycle+1: csr_regs[4]=0xDEADBEEF, csr_wr_en=1, csr_wr_idx=4, BVALID=1, BRESP=0.
- W first, AW 3 cycles later, WSTRB=4'b0011, data 0x12345678 onto reg 5 holding 0xAAAAAAAA → reg 5 = 0xAAAA5678; commit occurs 1 cycle after the AW handshake.
- Hold ro_regs slot 27 = 1000; read byte address 4*219 → RVALID next cycle with RDATA=1000.
- Write 0x55 to index 200 → BVALID with OKAY, no csr_wr_en; a subsequent read of index 200 returns the ro_regs value, not 0x55.
- Hold BREADY=0 for 5 cycles with a second AW/W pair issued → second commit occurs only the cycle after the first B handshake; 2 B responses are returned in order.
- Assert rst_n=0 while RVALID=1 and AW held → next cycle RVALID=0, AWREADY=1, all csr_regs=0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR definitions: register-file geometry, engine-visible register indices,
// channel FSM states and the write-data payload carried through the W holding stage.
package csr_pkg;

  localparam int unsigned CSR_REG_NUM = 256;
  localparam int unsigned RO_BASE     = 192;
  localparam int unsigned CSR_IDX_W   = $clog2(CSR_REG_NUM);
  localparam int unsigned CSR_ADDR_W  = CSR_IDX_W + 2;
  localparam int unsigned CSR_DATA_W  = 32;
  localparam int unsigned CSR_STRB_W  = CSR_DATA_W / 8;

  typedef logic [CSR_IDX_W-1:0] csr_idx_t;

  // Softmax engine configuration (read/write region)
  localparam csr_idx_t SMX_HEAD       = CSR_IDX_W'(16);
  localparam csr_idx_t SMX_WIN        = CSR_IDX_W'(17);
  localparam csr_idx_t SMX_CH         = CSR_IDX_W'(18);
  localparam csr_idx_t SMX_SRC_ADDR   = CSR_IDX_W'(19);
  localparam csr_idx_t SMX_DST_ADDR   = CSR_IDX_W'(20);
  localparam csr_idx_t SMX_STRIDE     = CSR_IDX_W'(21);

  // Status / performance counters (read-only region)
  localparam csr_idx_t DMA_DAT_PERF_CNT = CSR_IDX_W'(RO_BASE + 27);

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic [CSR_DATA_W-1:0] data;
    logic [CSR_STRB_W-1:0] strb;
  } csr_wdata_t;

  localparam int unsigned CSR_WDATA_W = $bits(csr_wdata_t);

  // Merge new_w into old_w on the strobed byte lanes only
  function automatic logic [CSR_DATA_W-1:0] apply_strb(
    input logic [CSR_DATA_W-1:0] old_w,
    input logic [CSR_DATA_W-1:0] new_w,
    input logic [CSR_STRB_W-1:0] strb
  );
    logic [CSR_DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < int'(CSR_STRB_W); b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/csr_axil_slave_if.sv
// AXI4-Lite control-port bundle between the CPU (master) and the CSR block (slave).
interface csr_axil_slave_if
  import csr_pkg::*;
#(
  parameter int unsigned ADDR_W = CSR_ADDR_W
);

  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport master (
    output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/csr_axil_wr_hold.sv
// One-deep capture stage for an AXI-Lite AW or W channel. The incoming beat is
// bypassed to avail_c/payload_c in its handshake cycle so a commit can consume it
// immediately; otherwise it is held until clear_i.
module csr_axil_wr_hold
  import csr_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [W-1:0] payload_i,
  input  logic         clear_i,
  output logic         ready_o,
  output logic         avail_c,
  output logic [W-1:0] payload_c
);

  logic         held_q;
  logic         ready_q;
  logic [W-1:0] payload_q;
  logic         hs_c;

  assign hs_c      = valid_i & ready_q;
  assign ready_o   = ready_q;
  assign avail_c   = held_q | hs_c;
  assign payload_c = held_q ? payload_q : payload_i;

  // Hold a beat until the commit consumes it; a beat consumed in its own cycle is never held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q    <= 1'b0;
      ready_q   <= 1'b1;
      payload_q <= '0;
    end else if (clear_i) begin
      held_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (hs_c) begin
      held_q    <= 1'b1;
      ready_q   <= 1'b0;
      payload_q <= payload_i;
    end
  end

endmodule

// File: rtl/csr_axil_slave.sv
// AXI4-Lite CSR responder: R/W configuration registers below RO_BASE, engine-supplied
// read-only status/counters from RO_BASE upward.
module csr_axil_slave
  import csr_pkg::*;
#(
  parameter int unsigned CSR_REG_NUM = csr_pkg::CSR_REG_NUM,
  parameter int unsigned ADDR_W      = $clog2(CSR_REG_NUM) + 2,
  parameter int unsigned RO_BASE     = csr_pkg::RO_BASE
) (
  input  logic                                clk,
  input  logic                                rst_n,
  csr_axil_slave_if.slave                     s_axi,
  output logic [RO_BASE*32-1:0]               csr_regs,
  input  logic [(CSR_REG_NUM-RO_BASE)*32-1:0] ro_regs,
  output logic                                csr_wr_en,
  output logic [$clog2(CSR_REG_NUM)-1:0]      csr_wr_idx
);

  localparam int unsigned IDX_W    = ADDR_W - 2;
  localparam int unsigned WIDX_W   = $clog2(CSR_REG_NUM);
  localparam int unsigned RO_NUM   = CSR_REG_NUM - RO_BASE;
  localparam int unsigned RO_IDX_W = (RO_NUM > 1) ? $clog2(RO_NUM) : 1;
  localparam logic [IDX_W-1:0] RO_IDX = IDX_W'(RO_BASE);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic                   commit_c;
  logic                   ar_hs_c;
  logic                   aw_ready;
  logic                   w_ready;
  logic                   aw_avail_c;
  logic                   w_avail_c;
  logic [IDX_W-1:0]       aw_idx_c;
  logic [CSR_WDATA_W-1:0] w_in_c;
  logic [CSR_WDATA_W-1:0] w_bits_c;
  csr_wdata_t             w_pay_c;
  logic                   is_rw_c;

  logic [RO_BASE*32-1:0]  regs_q;
  logic                   wr_en_q;
  logic [WIDX_W-1:0]      wr_idx_q;
  logic [31:0]            rdata_q;

  logic [IDX_W-1:0]       rd_idx_c;
  logic [RO_IDX_W-1:0]    ro_off_c;
  logic [31:0]            rd_word_c;
  logic                   unused_c;

  // Protection bits and sub-word address bits carry no meaning for this register file
  assign unused_c = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  assign w_in_c  = {s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB};
  assign w_pay_c = csr_wdata_t'(w_bits_c);
  assign is_rw_c = (aw_idx_c < RO_IDX);

  csr_axil_wr_hold #(.W(IDX_W)) u_aw_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (s_axi.S_AXI_AWVALID),
    .payload_i (s_axi.S_AXI_AWADDR[ADDR_W-1:2]),
    .clear_i   (commit_c),
    .ready_o   (aw_ready),
    .avail_c   (aw_avail_c),
    .payload_c (aw_idx_c)
  );

  csr_axil_wr_hold #(.W(CSR_WDATA_W)) u_w_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (s_axi.S_AXI_WVALID),
    .payload_i (w_in_c),
    .clear_i   (commit_c),
    .ready_o   (w_ready),
    .avail_c   (w_avail_c),
    .payload_c (w_bits_c)
  );

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = (wr_state_q == WR_RESP);
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = (rd_state_q == RD_IDLE);
  assign s_axi.S_AXI_RVALID  = (rd_state_q == RD_DATA);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign csr_regs   = regs_q;
  assign csr_wr_en  = wr_en_q;
  assign csr_wr_idx = wr_idx_q;

  // Channel state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Write channel: commit only while no B response is outstanding
  always_comb begin
    wr_state_d = wr_state_q;
    commit_c   = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_avail_c && w_avail_c) begin
          commit_c   = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.S_AXI_BREADY) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read channel: accept an address only when no read data is pending
  always_comb begin
    rd_state_d = rd_state_q;
    ar_hs_c    = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi.S_AXI_ARVALID) begin
          ar_hs_c    = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi.S_AXI_RREADY) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Register file update on commit; writes into the read-only window are dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q   <= '0;
      wr_en_q  <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (commit_c && is_rw_c) begin
        regs_q[{aw_idx_c, 5'b0} +: 32] <= apply_strb(regs_q[{aw_idx_c, 5'b0} +: 32],
                                                     w_pay_c.data, w_pay_c.strb);
        wr_en_q  <= 1'b1;
        wr_idx_q <= WIDX_W'(aw_idx_c);
      end
    end
  end

  // Read source select: local register or engine-supplied read-only slot
  always_comb begin
    rd_idx_c  = s_axi.S_AXI_ARADDR[ADDR_W-1:2];
    ro_off_c  = RO_IDX_W'(rd_idx_c - RO_IDX);
    rd_word_c = '0;
    if (rd_idx_c < RO_IDX) begin
      rd_word_c = regs_q[{rd_idx_c, 5'b0} +: 32];
    end else begin
      rd_word_c = ro_regs[{ro_off_c, 5'b0} +: 32];
    end
  end

  // Read data is captured in the address handshake cycle and held until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (ar_hs_c) begin
      rdata_q <= rd_word_c;
    end
  end

endmodule

// File: tb/tb_csr_axil_slave.sv
// Directed bench for csr_axil_slave: write/read paths, strobes, read-only window,
// B back-pressure, read-during-write and mid-transaction reset.
module tb_csr_axil_slave;

  logic          clk;
  logic          rst_n;
  logic [6143:0] csr_regs;
  logic [2047:0] ro_regs;
  logic          csr_wr_en;
  logic [7:0]    csr_wr_idx;

  int checks   = 0;
  int failures = 0;

  csr_axil_slave_if #(.ADDR_W(10)) bus ();

  csr_axil_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axi      (bus.slave),
    .csr_regs   (csr_regs),
    .ro_regs    (ro_regs),
    .csr_wr_en  (csr_wr_en),
    .csr_wr_idx (csr_wr_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return csr_regs[32*i +: 32];
  endfunction

  task automatic drive_aw(input logic v, input int idx);
    bus.S_AXI_AWVALID = v;
    bus.S_AXI_AWADDR  = 10'(idx * 4);
  endtask

  task automatic drive_w(input logic v, input logic [31:0] d, input logic [3:0] s);
    bus.S_AXI_WVALID = v;
    bus.S_AXI_WDATA  = d;
    bus.S_AXI_WSTRB  = s;
  endtask

  task automatic drive_ar(input logic v, input int idx);
    bus.S_AXI_ARVALID = v;
    bus.S_AXI_ARADDR  = 10'(idx * 4);
  endtask

  task automatic b_take();
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.S_AXI_AWREADY !== 1'b1) begin failures++; $display("FAIL reset_awready got=%0b exp=1", bus.S_AXI_AWREADY); end
    checks++; if (bus.S_AXI_WREADY !== 1'b1) begin failures++; $display("FAIL reset_wready got=%0b exp=1", bus.S_AXI_WREADY); end
    checks++; if (bus.S_AXI_ARREADY !== 1'b1) begin failures++; $display("FAIL reset_arready got=%0b exp=1", bus.S_AXI_ARREADY); end
    checks++; if (bus.S_AXI_BVALID !== 1'b0) begin failures++; $display("FAIL reset_bvalid got=%0b exp=0", bus.S_AXI_BVALID); end
    checks++; if (bus.S_AXI_RVALID !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0b exp=0", bus.S_AXI_RVALID); end
    checks++; if (bus.S_AXI_BRESP !== 2'b00 || bus.S_AXI_RRESP !== 2'b00) begin failures++; $display("FAIL reset_resp got=%0h/%0h exp=0/0", bus.S_AXI_BRESP, bus.S_AXI_RRESP); end
    checks++; if (csr_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0b exp=0", csr_wr_en); end
    checks++; if (bus.S_AXI_RDATA !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.S_AXI_RDATA); end
    checks++; if (csr_regs !== '0) begin failures++; $display("FAIL reset_regs got=nonzero exp=0"); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_same_cycle();
    drive_aw(1'b1, 4);
    drive_w(1'b1, 32'hDEADBEEF, 4'hF);
    tick();
    drive_aw(1'b0, 0);
    drive_w(1'b0, 32'h0, 4'h0);
    checks++; if (reg_at(4) !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_same_reg4 got=%h exp=deadbeef", reg_at(4)); end
    checks++; if (csr_wr_en !== 1'b1) begin failures++; $display("FAIL wr_same_wr_en got=%0b exp=1", csr_wr_en); end
    checks++; if (csr_wr_idx !== 8'd4) begin failures++; $display("FAIL wr_same_idx got=%0d exp=4", csr_wr_idx); end
    checks++; if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin failures++; $display("FAIL wr_same_b got=%0b/%0h exp=1/0", bus.S_AXI_BVALID, bus.S_AXI_BRESP); end
    checks++; if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_WREADY !== 1'b1) begin failures++; $display("FAIL wr_same_ready got=%0b%0b exp=11", bus.S_AXI_AWREADY, bus.S_AXI_WREADY); end
    b_take();
    checks++; if (bus.S_AXI_BVALID !== 1'b0 || csr_wr_en !== 1'b0) begin failures++; $display("FAIL wr_same_after_b got=%0b/%0b exp=0/0", bus.S_AXI_BVALID, csr_wr_en); end
  endtask

  task automatic test_strobe_w_first();
    drive_aw(1'b1, 5);
    drive_w(1'b1, 32'hAAAAAAAA, 4'hF);
    tick();
    drive_aw(1'b0, 0);
    drive_w(1'b0, 32'h0, 4'h0);
    b_take();
    checks++; if (reg_at(5) !== 32'hAAAAAAAA) begin failures++; $display("FAIL strb_preload got=%h exp=aaaaaaaa", reg_at(5)); end
    drive_w(1'b1, 32'h12345678, 4'b0011);
    tick();
    drive_w(1'b0, 32'h0, 4'h0);
    checks++; if (bus.S_AXI_WREADY !== 1'b0 || csr_wr_en !== 1'b0 || bus.S_AXI_BVALID !== 1'b0) begin failures++; $display("FAIL strb_w_held got=wready%0b wr_en%0b bvalid%0b exp=000", bus.S_AXI_WREADY, csr_wr_en, bus.S_AXI_BVALID); end
    tick();
    tick();
    checks++; if (reg_at(5) !== 32'hAAAAAAAA || csr_wr_en !== 1'b0) begin failures++; $display("FAIL strb_wait got=%h/%0b exp=aaaaaaaa/0", reg_at(5), csr_wr_en); end
    drive_aw(1'b1, 5);
    tick();
    drive_aw(1'b0, 0);
    checks++; if (reg_at(5) !== 32'hAAAA5678) begin failures++; $display("FAIL strb_merge got=%h exp=aaaa5678", reg_at(5)); end
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_idx !== 8'd5) begin failures++; $display("FAIL strb_pulse got=%0b/%0d exp=1/5", csr_wr_en, csr_wr_idx); end
    checks++; if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_WREADY !== 1'b1) begin failures++; $display("FAIL strb_b got=%0b/%0b exp=1/1", bus.S_AXI_BVALID, bus.S_AXI_WREADY); end
    b_take();
  endtask

  task automatic test_ro_read();
    ro_regs[32*27 +: 32] = 32'd1000;
    drive_ar(1'b1, 219);
    tick();
    drive_ar(1'b0, 0);
    checks++; if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'd1000) begin failures++; $display("FAIL ro_read got=%0b/%0d exp=1/1000", bus.S_AXI_RVALID, bus.S_AXI_RDATA); end
    checks++; if (bus.S_AXI_ARREADY !== 1'b0 || bus.S_AXI_RRESP !== 2'b00) begin failures++; $display("FAIL ro_read_arready got=%0b/%0h exp=0/0", bus.S_AXI_ARREADY, bus.S_AXI_RRESP); end
    ro_regs[32*27 +: 32] = 32'd5;
    tick();
    checks++; if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'd1000) begin failures++; $display("FAIL ro_read_held got=%0b/%0d exp=1/1000", bus.S_AXI_RVALID, bus.S_AXI_RDATA); end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    checks++; if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1) begin failures++; $display("FAIL ro_read_done got=%0b/%0b exp=0/1", bus.S_AXI_RVALID, bus.S_AXI_ARREADY); end
    drive_ar(1'b1, 5);
    tick();
    drive_ar(1'b0, 0);
    checks++; if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'hAAAA5678) begin failures++; $display("FAIL rw_read got=%0b/%h exp=1/aaaa5678", bus.S_AXI_RVALID, bus.S_AXI_RDATA); end
    tick();
    checks++; if (bus.S_AXI_RVALID !== 1'b0) begin failures++; $display("FAIL rw_read_done got=%0b exp=0", bus.S_AXI_RVALID); end
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_ro_write();
    ro_regs[32*8 +: 32]  = 32'h0BADF00D;
    ro_regs[32*63 +: 32] = 32'h77770255;
    drive_aw(1'b1, 200);
    drive_w(1'b1, 32'h00000055, 4'hF);
    tick();
    drive_aw(1'b0, 0);
    drive_w(1'b0, 32'h0, 4'h0);
    checks++; if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin failures++; $display("FAIL ro_wr_b got=%0b/%0h exp=1/0", bus.S_AXI_BVALID, bus.S_AXI_BRESP); end
    checks++; if (csr_wr_en !== 1'b0) begin failures++; $display("FAIL ro_wr_no_pulse got=%0b exp=0", csr_wr_en); end
    b_take();
    drive_ar(1'b1, 200);
    tick();
    drive_ar(1'b0, 0);
    checks++; if (bus.S_AXI_RDATA !== 32'h0BADF00D) begin failures++; $display("FAIL ro_wr_readback got=%h exp=0badf00d", bus.S_AXI_RDATA); end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    drive_aw(1'b1, 191);
    drive_w(1'b1, 32'hCAFE0191, 4'hF);
    tick();
    drive_aw(1'b0, 0);
    drive_w(1'b0, 32'h0, 4'h0);
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_idx !== 8'd191 || reg_at(191) !== 32'hCAFE0191) begin failures++; $display("FAIL rw_top_write got=%0b/%0d/%h exp=1/191/cafe0191", csr_wr_en, csr_wr_idx, reg_at(191)); end
    b_take();
    drive_ar(1'b1, 255);
    tick();
    drive_ar(1'b0, 0);
    checks++; if (bus.S_AXI_RDATA !== 32'h77770255) begin failures++; $display("FAIL ro_last_read got=%h exp=77770255", bus.S_AXI_RDATA); end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_read_during_write();
    drive_aw(1'b1, 4);
    drive_w(1'b1, 32'h11111111, 4'hF);
    drive_ar(1'b1, 4);
    tick();
    drive_aw(1'b0, 0);
    drive_w(1'b0, 32'h0, 4'h0);
    drive_ar(1'b0, 0);
    checks++; if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_old_value got=%0b/%h exp=1/deadbeef", bus.S_AXI_RVALID, bus.S_AXI_RDATA); end
    checks++; if (reg_at(4) !== 32'h11111111 || csr_wr_en !== 1'b1) begin failures++; $display("FAIL raw_reg_updated got=%h/%0b exp=11111111/1", reg_at(4), csr_wr_en); end
    bus.S_AXI_RREADY = 1'b1;
    b_take();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_aw(1'b1, 10);
    drive_w(1'b1, 32'h0000000A, 4'hF);
    tick();
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_idx !== 8'd10 || bus.S_AXI_BVALID !== 1'b1) begin failures++; $display("FAIL b2b_first got=%0b/%0d/%0b exp=1/10/1", csr_wr_en, csr_wr_idx, bus.S_AXI_BVALID); end
    drive_aw(1'b1, 11);
    drive_w(1'b1, 32'h0000000B, 4'hF);
    tick();
    drive_aw(1'b0, 0);
    drive_w(1'b0, 32'h0, 4'h0);
    checks++; if (bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b0) begin failures++; $display("FAIL b2b_held got=%0b%0b exp=00", bus.S_AXI_AWREADY, bus.S_AXI_WREADY); end
    checks++; if (csr_wr_en !== 1'b0 || reg_at(11) !== 32'h0) begin failures++; $display("FAIL b2b_no_early got=%0b/%h exp=0/0", csr_wr_en, reg_at(11)); end
    repeat (3) tick();
    checks++; if (bus.S_AXI_BVALID !== 1'b1 || csr_wr_en !== 1'b0 || reg_at(11) !== 32'h0) begin failures++; $display("FAIL b2b_stall got=%0b/%0b/%h exp=1/0/0", bus.S_AXI_BVALID, csr_wr_en, reg_at(11)); end
    b_take();
    checks++; if (bus.S_AXI_BVALID !== 1'b0 || csr_wr_en !== 1'b0 || reg_at(11) !== 32'h0) begin failures++; $display("FAIL b2b_gap got=%0b/%0b/%h exp=0/0/0", bus.S_AXI_BVALID, csr_wr_en, reg_at(11)); end
    tick();
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_idx !== 8'd11 || reg_at(11) !== 32'h0000000B) begin failures++; $display("FAIL b2b_second got=%0b/%0d/%h exp=1/11/b", csr_wr_en, csr_wr_idx, reg_at(11)); end
    checks++; if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_AWREADY !== 1'b1) begin failures++; $display("FAIL b2b_second_b got=%0b/%0b exp=1/1", bus.S_AXI_BVALID, bus.S_AXI_AWREADY); end
    b_take();
    checks++; if (bus.S_AXI_BVALID !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0b exp=0", bus.S_AXI_BVALID); end
  endtask

  task automatic test_reset_mid();
    drive_ar(1'b1, 4);
    tick();
    drive_ar(1'b0, 0);
    drive_aw(1'b1, 6);
    tick();
    drive_aw(1'b0, 0);
    checks++; if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_AWREADY !== 1'b0) begin failures++; $display("FAIL rstmid_pre got=%0b/%0b exp=1/0", bus.S_AXI_RVALID, bus.S_AXI_AWREADY); end
    rst_n = 1'b0;
    tick();
    checks++; if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_AWREADY !== 1'b1) begin failures++; $display("FAIL rstmid_ch got=%0b/%0b exp=0/1", bus.S_AXI_RVALID, bus.S_AXI_AWREADY); end
    checks++; if (csr_regs !== '0 || bus.S_AXI_RDATA !== 32'h0) begin failures++; $display("FAIL rstmid_regs got=rdata%h exp=0 and regs cleared", bus.S_AXI_RDATA); end
    rst_n = 1'b1;
    drive_w(1'b1, 32'h00000099, 4'hF);
    tick();
    drive_w(1'b0, 32'h0, 4'h0);
    checks++; if (csr_wr_en !== 1'b0 || bus.S_AXI_BVALID !== 1'b0) begin failures++; $display("FAIL rstmid_aw_dropped got=%0b/%0b exp=0/0", csr_wr_en, bus.S_AXI_BVALID); end
    drive_aw(1'b1, 6);
    tick();
    drive_aw(1'b0, 0);
    checks++; if (csr_wr_en !== 1'b1 || reg_at(6) !== 32'h00000099) begin failures++; $display("FAIL rstmid_recover got=%0b/%h exp=1/99", csr_wr_en, reg_at(6)); end
    b_take();
  endtask

  initial begin
    rst_n   = 1'b0;
    ro_regs = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWPROT  = 3'b000;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = 3'b000;
    bus.S_AXI_RREADY  = 1'b0;
    #2;
    test_reset();
    test_write_same_cycle();
    test_strobe_w_first();
    test_ro_read();
    test_ro_write();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
